uart_frame_decoder: RTL

UART_FRAME_DECODER -- requirements
Module: uart_frame_decoder

---
 rtl/uart_frame_decoder.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder
// Turns a stream of received UART bytes into checked, word-packed frames.
// A frame is: SYNC SYNC LEN payload[LEN] CHECKSUM. The checksum is LEN XOR
// every payload byte. Only a frame whose checksum matches is replayed on the
// output, one 32-bit little-endian word at a time. Upstream is held off with
// io_in_ready low while those words drain.
module uart_frame_decoder #(
  parameter logic [7:0] SYNC_BYTE = 8'hCA,
  parameter int         MAX_WORDS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_in_valid,
  input  logic [7:0]  io_in_bits,
  output logic        io_in_ready,
  output logic        io_out_valid,
  output logic [31:0] io_out_bits,
  output logic        io_out_last,
  input  logic        io_out_ready,
  output logic [7:0]  io_frame_count,
  output logic [7:0]  io_err_count
);

  localparam int          WIDX_W    = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam int unsigned MAX_BYTES = 4 * MAX_WORDS;

  typedef enum logic [2:0] {
    IDLE,
    SYNC1,
    LEN,
    PAYLOAD,
    CHECK,
    DRAIN
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [7:0]          chk_q, chk_d;
  logic [WIDX_W-1:0]   widx_q, widx_d;
  logic [WIDX_W-1:0]   lastIdx_q, lastIdx_d;
  logic                outValid_q, outValid_d;
  logic [31:0]         outBits_q, outBits_d;
  logic                outLast_q, outLast_d;
  logic                inReady_q, inReady_d;
  logic [7:0]          frameCnt_q, frameCnt_d;
  logic [7:0]          errCnt_q, errCnt_d;

  logic [31:0]         buf_q [MAX_WORDS];

  logic                byteFire;
  logic                wordFire;
  logic                lenOk;
  logic [5:0]          lenWordsM1;
  logic [WIDX_W-1:0]   widxNext;
  logic [7:0]          errCntInc;
  logic [WIDX_W-1:0]   wrWord;
  logic [4:0]          wrOffset;

  assign byteFire   = io_in_valid && inReady_q;
  assign wordFire   = outValid_q && io_out_ready;
  assign lenOk      = (io_in_bits != 8'd0) && (io_in_bits[1:0] == 2'b00) &&
                      (32'(io_in_bits) <= MAX_BYTES);
  assign lenWordsM1 = io_in_bits[7:2] - 6'd1;
  assign widxNext   = widx_q + WIDX_W'(1);
  assign errCntInc  = (errCnt_q == 8'hFF) ? errCnt_q : errCnt_q + 8'd1;
  assign wrWord     = cnt_q[WIDX_W+1:2];
  assign wrOffset   = {cnt_q[1:0], 3'b000};

  assign io_in_ready    = inReady_q;
  assign io_out_valid   = outValid_q;
  assign io_out_bits    = outBits_q;
  assign io_out_last    = outLast_q;
  assign io_frame_count = frameCnt_q;
  assign io_err_count   = errCnt_q;

  // Next-state logic: walk the frame byte by byte, then replay the buffer.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    chk_d      = chk_q;
    widx_d     = widx_q;
    lastIdx_d  = lastIdx_q;
    outValid_d = outValid_q;
    outBits_d  = outBits_q;
    outLast_d  = outLast_q;
    frameCnt_d = frameCnt_q;
    errCnt_d   = errCnt_q;

    case (state_q)
      IDLE: begin
        if (byteFire && (io_in_bits == SYNC_BYTE)) begin
          state_d = SYNC1;
        end
      end

      SYNC1: begin
        if (byteFire) begin
          state_d = (io_in_bits == SYNC_BYTE) ? LEN : IDLE;
        end
      end

      LEN: begin
        if (byteFire) begin
          if (lenOk) begin
            state_d   = PAYLOAD;
            len_d     = io_in_bits;
            chk_d     = io_in_bits;
            cnt_d     = 8'd0;
            lastIdx_d = lenWordsM1[WIDX_W-1:0];
          end else begin
            state_d  = IDLE;
            errCnt_d = errCntInc;
          end
        end
      end

      PAYLOAD: begin
        if (byteFire) begin
          chk_d = chk_q ^ io_in_bits;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == (len_q - 8'd1)) begin
            state_d = CHECK;
          end
        end
      end

      CHECK: begin
        if (byteFire) begin
          if (io_in_bits == chk_q) begin
            state_d    = DRAIN;
            widx_d     = '0;
            outValid_d = 1'b1;
            outBits_d  = buf_q[0];
            outLast_d  = (lastIdx_q == '0);
          end else begin
            state_d  = IDLE;
            errCnt_d = errCntInc;
          end
        end
      end

      DRAIN: begin
        if (wordFire) begin
          if (outLast_q) begin
            state_d    = IDLE;
            outValid_d = 1'b0;
            outBits_d  = 32'd0;
            outLast_d  = 1'b0;
            frameCnt_d = frameCnt_q + 8'd1;
          end else begin
            widx_d    = widxNext;
            outBits_d = buf_q[widxNext];
            outLast_d = (widxNext == lastIdx_q);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    inReady_d = (state_d != DRAIN);
  end

  // State and output registers; reset abandons any frame, even mid-drain.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      len_q      <= 8'd0;
      cnt_q      <= 8'd0;
      chk_q      <= 8'd0;
      widx_q     <= '0;
      lastIdx_q  <= '0;
      outValid_q <= 1'b0;
      outBits_q  <= 32'd0;
      outLast_q  <= 1'b0;
      inReady_q  <= 1'b1;
      frameCnt_q <= 8'd0;
      errCnt_q   <= 8'd0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      chk_q      <= chk_d;
      widx_q     <= widx_d;
      lastIdx_q  <= lastIdx_d;
      outValid_q <= outValid_d;
      outBits_q  <= outBits_d;
      outLast_q  <= outLast_d;
      inReady_q  <= inReady_d;
      frameCnt_q <= frameCnt_d;
      errCnt_q   <= errCnt_d;
    end
  end

  // Payload buffer; left uninitialised since it is only read after a full frame.
  always_ff @(posedge clock) begin
    if ((state_q == PAYLOAD) && byteFire) begin
      buf_q[wrWord][wrOffset +: 8] <= io_in_bits;
    end
  end

endmodule
